// File: rtl/flexsched_pkg.sv
// Shared types and defaults for the flexcounter scheduler.
package flexsched_pkg;

  localparam int unsigned NREQ_DEFAULT      = 4;
  localparam int unsigned COUNTSIZE_DEFAULT = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/flexcounter_if.sv
// Handshake between a counter owner (controller) and a flexcounter instance.
interface flexcounter_if #(
  parameter int unsigned COUNTWIDTH = 10
);

  logic                  clk;
  logic                  nRST;
  logic                  enableCounter;
  logic [COUNTWIDTH-1:0] maxCount;
  logic                  strobe;
  logic [COUNTWIDTH-1:0] count;

  modport controller (
    output clk, nRST, enableCounter, maxCount,
    input  strobe, count
  );

  modport counter (
    input  clk, nRST, enableCounter, maxCount,
    output strobe, count
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  int unsigned slot;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    slot  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      slot = (32'(ptr) + i) % NREQ;
      if (!valid && req[IDXW'(slot)]) begin
        valid = 1'b1;
        idx   = IDXW'(slot);
      end
    end
  end

endmodule

// File: rtl/flexcounter_scheduler.sv
// Time-shares one flexcounter among NREQ requesters with round-robin fairness.
module flexcounter_scheduler
  import flexsched_pkg::*;
#(
  parameter  int unsigned NREQ       = NREQ_DEFAULT,
  parameter  int unsigned COUNTSIZE  = COUNTSIZE_DEFAULT,
  localparam int unsigned COUNTWIDTH = $clog2(COUNTSIZE),
  localparam int unsigned IDXW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                             clk,
  input  logic                             RST,
  input  logic [NREQ-1:0]                  req,
  input  logic [NREQ-1:0][COUNTWIDTH-1:0]  req_count,
  output logic [NREQ-1:0]                  grant,
  output logic [NREQ-1:0]                  done,
  output logic                             busy,
  flexcounter_if.controller                fc
);

  sched_state_t          state, state_n;
  logic [IDXW-1:0]       winner, winner_n, winner_inc;
  logic [IDXW-1:0]       ptr, ptr_n, arb_ptr;
  logic [COUNTWIDTH-1:0] cur_max, cur_max_n;
  logic [NREQ-1:0]       grant_n, done_n;
  logic                  clr_q, en_q;
  logic [COUNTWIDTH-1:0] max_q;
  logic                  arb_valid;
  logic [IDXW-1:0]       arb_idx;

  assign winner_inc = (winner == IDXW'(NREQ - 1)) ? '0 : winner + IDXW'(1);

  // DONE already knows the next pointer, so it can hand over without an IDLE bubble.
  assign arb_ptr = (state == DONE) ? winner_inc : ptr;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (req),
    .ptr   (arb_ptr),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  always_comb begin
    state_n   = state;
    winner_n  = winner;
    cur_max_n = cur_max;
    ptr_n     = ptr;
    grant_n   = '0;
    done_n    = '0;
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          state_n   = LOAD;
          winner_n  = arb_idx;
          cur_max_n = req_count[arb_idx];
        end
      end
      LOAD: begin
        if (!req[winner]) begin
          state_n = IDLE;
          ptr_n   = winner_inc;
        end else if (cur_max == '0) begin
          state_n = DONE;
        end else begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (!req[winner]) begin
          state_n = IDLE;
          ptr_n   = winner_inc;
        end else if (fc.strobe) begin
          state_n = DONE;
        end
      end
      DONE: begin
        ptr_n = winner_inc;
        if (arb_valid) begin
          state_n   = LOAD;
          winner_n  = arb_idx;
          cur_max_n = req_count[arb_idx];
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != IDLE) grant_n = NREQ'(1) << winner_n;
    if (state_n == DONE) done_n  = NREQ'(1) << winner_n;
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      winner  <= '0;
      cur_max <= '0;
      ptr     <= '0;
      grant   <= '0;
      done    <= '0;
      busy    <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      max_q   <= '0;
    end else begin
      state   <= state_n;
      winner  <= winner_n;
      cur_max <= cur_max_n;
      ptr     <= ptr_n;
      grant   <= grant_n;
      done    <= done_n;
      busy    <= (state_n != IDLE);
      clr_q   <= (state_n == LOAD);
      en_q    <= (state_n == RUN);
      max_q   <= (state_n != IDLE) ? cur_max_n : '0;
    end
  end

  assign fc.clk           = clk;
  assign fc.nRST          = ~(RST | clr_q);
  assign fc.enableCounter = en_q;
  assign fc.maxCount      = max_q;

endmodule
